// File: rtl/wb_register_file_if.sv
// Writeback, read-port and scoreboard signals of the integer register file.
// The master drives indices, writeback and pending marks; the slave returns data and hazard status.
interface wb_register_file_if #(
    parameter int unsigned DATA_W = 32
);
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              pend_set;
    logic [4:0]        pend_rd;
    logic              stall;
    logic [31:0]       busy;

    modport master (
        output wb_en, wb_rd, wb_data, rs1, rs2, pend_set, pend_rd,
        input  rs1_data, rs2_data, stall, busy
    );

    modport slave (
        input  wb_en, wb_rd, wb_data, rs1, rs2, pend_set, pend_rd,
        output rs1_data, rs2_data, stall, busy
    );
endinterface

// File: rtl/wb_register_file.sv
// 32 x DATA_W register file with x0 hard-wired to zero, optional writeback forwarding,
// and a pending-write scoreboard that raises stall for operands not yet produced.
module wb_register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    wb_register_file_if.slave   bus
);
    logic [DATA_W-1:0] regs [32];
    logic [31:0]       busy_q;
    logic [31:0]       busy_next;
    logic              wr_fire;
    logic              set_fire;
    logic              fwd1;
    logic              fwd2;
    logic              hazard1;
    logic              hazard2;

    assign wr_fire  = bus.wb_en && (bus.wb_rd != 5'd0);
    assign set_fire = bus.pend_set && (bus.pend_rd != 5'd0);

    // Clear before set so a same-edge mark of the register being written leaves it busy.
    always_comb begin
        busy_next = busy_q;
        if (wr_fire) begin
            busy_next[bus.wb_rd] = 1'b0;
        end
        if (set_fire) begin
            busy_next[bus.pend_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_fire) begin
                regs[bus.wb_rd] <= bus.wb_data;
            end
            busy_q <= busy_next;
        end
    end

    always_comb begin
        fwd1 = (BYPASS != 0) && bus.wb_en && (bus.wb_rd == bus.rs1);
        fwd2 = (BYPASS != 0) && bus.wb_en && (bus.wb_rd == bus.rs2);
    end

    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1 != 5'd0) begin
            bus.rs1_data = fwd1 ? bus.wb_data : regs[bus.rs1];
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2 != 5'd0) begin
            bus.rs2_data = fwd2 ? bus.wb_data : regs[bus.rs2];
        end
    end

    always_comb begin
        hazard1   = (bus.rs1 != 5'd0) && busy_q[bus.rs1] && !fwd1;
        hazard2   = (bus.rs2 != 5'd0) && busy_q[bus.rs2] && !fwd2;
        bus.stall = hazard1 || hazard2;
        bus.busy  = busy_q;
    end
endmodule

// File: tb/tb_wb_register_file.sv
// Directed and randomized checks of wb_register_file with forwarding enabled and disabled,
// both instances driven identically and compared against an array-based reference model.
module tb_wb_register_file;
    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        pend_set;
    logic [4:0]  pend_rd;

    logic [31:0] mregs [32];
    logic [31:0] mbusy;

    int checks = 0;
    int errors = 0;

    wb_register_file_if #(.DATA_W(32)) bus_a ();
    wb_register_file_if #(.DATA_W(32)) bus_b ();

    assign bus_a.wb_en    = wb_en;
    assign bus_a.wb_rd    = wb_rd;
    assign bus_a.wb_data  = wb_data;
    assign bus_a.rs1      = rs1;
    assign bus_a.rs2      = rs2;
    assign bus_a.pend_set = pend_set;
    assign bus_a.pend_rd  = pend_rd;
    assign bus_b.wb_en    = wb_en;
    assign bus_b.wb_rd    = wb_rd;
    assign bus_b.wb_data  = wb_data;
    assign bus_b.rs1      = rs1;
    assign bus_b.rs2      = rs2;
    assign bus_b.pend_set = pend_set;
    assign bus_b.pend_rd  = pend_rd;

    wb_register_file #(.DATA_W(32), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    wb_register_file #(.DATA_W(32), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit bp);
        if (idx == 5'd0) return 32'd0;
        if (bp && wb_en && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    function automatic logic exp_stall(input bit bp);
        logic s = 1'b0;
        if (rs1 != 0 && mbusy[rs1] && !(bp && wb_en && wb_rd == rs1)) s = 1'b1;
        if (rs2 != 0 && mbusy[rs2] && !(bp && wb_en && wb_rd == rs2)) s = 1'b1;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                          input logic [4:0] a, input logic [4:0] b, input logic ps, input logic [4:0] prd);
        rst = r; wb_en = we; wb_rd = wrd; wb_data = wd;
        rs1 = a; rs2 = b; pend_set = ps; pend_rd = prd;
    endtask

    task automatic check_all();
        #1;
        chk("a_rs1_data", bus_a.rs1_data, exp_rd(rs1, 1'b1));
        chk("a_rs2_data", bus_a.rs2_data, exp_rd(rs2, 1'b1));
        chk("a_stall", {31'd0, bus_a.stall}, {31'd0, exp_stall(1'b1)});
        chk("a_busy", bus_a.busy, mbusy);
        chk("b_rs1_data", bus_b.rs1_data, exp_rd(rs1, 1'b0));
        chk("b_rs2_data", bus_b.rs2_data, exp_rd(rs2, 1'b0));
        chk("b_stall", {31'd0, bus_b.stall}, {31'd0, exp_stall(1'b0)});
        chk("b_busy", bus_b.busy, mbusy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mbusy = 32'd0;
        end else begin
            if (wb_en && wb_rd != 0) begin
                mregs[wb_rd] = wb_data;
                mbusy[wb_rd] = 1'b0;
            end
            if (pend_set && pend_rd != 0) mbusy[pend_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'hx;
        mbusy = 32'hx;
        @(negedge clk);
        set_in(1, 1, 5'd3, 32'h0BAD_0BAD, 0, 0, 1, 5'd3);
        tick();

        // Post-reset state: every index reads zero, nothing pending
        set_in(0, 0, 0, 0, 5'd3, 5'd31, 0, 0);
        check_all();
        chk("reset_busy", bus_a.busy, 32'd0);
        chk("reset_rd3", bus_a.rs1_data, 32'd0);
        chk("reset_stall", {31'd0, bus_a.stall}, 32'd0);

        // Write x5, read it back next cycle
        set_in(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        check_all(); tick();
        set_in(0, 0, 0, 0, 5'd5, 5'd0, 0, 0);
        check_all();
        chk("x5_read", bus_a.rs1_data, 32'hDEADBEEF);
        chk("x0_read", bus_a.rs2_data, 32'd0);
        tick();

        // Writes to x0 are discarded and never forwarded
        set_in(0, 1, 5'd0, 32'h1234, 0, 0, 1, 5'd0);
        check_all();
        chk("x0_fwd", bus_a.rs1_data, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all();
        chk("x0_after", bus_a.rs1_data, 32'd0);
        chk("busy0", {31'd0, bus_a.busy[0]}, 32'd0);
        tick();

        // Forwarding vs. old-value read
        set_in(0, 1, 5'd7, 32'h11, 0, 0, 0, 0);
        check_all(); tick();
        set_in(0, 1, 5'd7, 32'h22, 0, 5'd7, 0, 0);
        check_all();
        chk("fwd_a", bus_a.rs2_data, 32'h22);
        chk("nofwd_b", bus_b.rs2_data, 32'h11);
        chk("fwd_stall", {31'd0, bus_a.stall}, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 5'd7, 0, 0);
        check_all();
        chk("next_b", bus_b.rs2_data, 32'h22);
        tick();

        // Scoreboard: pending x9 stalls until its writeback
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd9);
        check_all(); tick();
        set_in(0, 0, 0, 0, 5'd9, 0, 0, 0);
        check_all();
        chk("pend_stall", {31'd0, bus_a.stall}, 32'd1);
        chk("pend_busy", bus_a.busy, 32'h200);
        tick();
        set_in(0, 1, 5'd9, 32'h55, 5'd9, 0, 0, 0);
        check_all();
        chk("wb_unstall_a", {31'd0, bus_a.stall}, 32'd0);
        chk("wb_stall_b", {31'd0, bus_b.stall}, 32'd1);
        chk("wb_fwd9", bus_a.rs1_data, 32'h55);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all();
        chk("busy_cleared", bus_a.busy, 32'd0);
        tick();

        // Same-edge set and writeback: write lands, set wins
        set_in(0, 1, 5'd3, 32'hA, 0, 0, 1, 5'd3);
        check_all(); tick();
        set_in(0, 0, 0, 0, 5'd3, 0, 0, 0);
        check_all();
        chk("x3_val", bus_a.rs1_data, 32'hA);
        chk("x3_busy", bus_a.busy, 32'h8);
        tick();
        set_in(0, 1, 5'd3, 32'hB, 0, 0, 0, 0);
        check_all(); tick();

        // Reset wipes pending state; later writes are normal
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd4);
        check_all(); tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 5'd6);
        check_all(); tick();
        set_in(0, 1, 5'd4, 32'hF, 5'd4, 5'd6, 1, 5'd6);
        check_all(); tick();
        set_in(1, 1, 5'd6, 32'h99, 5'd4, 5'd6, 1, 5'd6);
        check_all(); tick();
        set_in(0, 0, 0, 0, 5'd4, 5'd6, 0, 0);
        check_all();
        chk("rst_busy", bus_a.busy, 32'd0);
        chk("rst_x4", bus_a.rs1_data, 32'd0);
        chk("rst_stall", {31'd0, bus_a.stall}, 32'd0);
        tick();
        set_in(0, 1, 5'd6, 32'h66, 0, 0, 0, 0);
        check_all(); tick();
        set_in(0, 0, 0, 0, 0, 5'd6, 0, 0);
        check_all();
        chk("x6_after_rst", bus_b.rs2_data, 32'h66);
        tick();

        // Randomized traffic concentrated on a few registers to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            set_in($urandom_range(0, 60) == 0,
                   $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, int'(hi))),
                   $urandom,
                   5'($urandom_range(0, int'(hi))),
                   5'($urandom_range(0, int'(hi))),
                   $urandom_range(0, 2) == 0,
                   5'($urandom_range(0, int'(hi))));
            check_all();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_register_file.md
WB_REGISTER_FILE -- requirements
Module: wb_register_file

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and of the writeback and read data.
REQ-002 Parameter BYPASS, default 1, enables same-cycle writeback-to-read forwarding when 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wb_en  input  1  writeback valid; the selected writeback word is present this cycle.
REQ-006 wb_rd  input  5  writeback destination register index.
REQ-007 wb_data  input  DATA_W  writeback word, i.e. the output of the writeback select mux.
REQ-008 rs1, rs2  input  5 each  read port indices.
REQ-009 rs1_data, rs2_data  output  DATA_W each  read port data, combinational.
REQ-010 pend_set  input  1  an issued load or long-latency operation will later write pend_rd.
REQ-011 pend_rd  input  5  destination index being marked pending.
REQ-012 stall  output  1  a read operand is pending and not yet available.
REQ-013 busy  output  32  registered scoreboard bit vector; bit i=1 means register i is pending.

Function
REQ-014 32 registers x0..x31 of DATA_W bits; x0 SHALL read 0 and SHALL never be written.
REQ-015 Write: at a rising edge with wb_en=1 and wb_rd!=0, reg[wb_rd] <= wb_data; otherwise no register changes.
REQ-016 Read: rsN_data = 0 if rsN=0; else if BYPASS=1, wb_en=1 and wb_rd=rsN, then wb_data; else reg[rsN].
REQ-017 With BYPASS=0, a read of a register being written returns the old value in that cycle and the new value from the next cycle.
REQ-018 Scoreboard set: at an edge with pend_set=1 and pend_rd!=0, busy[pend_rd] <= 1.
REQ-019 Scoreboard clear: at an edge with wb_en=1 and wb_rd!=0, busy[wb_rd] <= 0.
REQ-020 Same edge with pend_set, wb_en and pend_rd=wb_rd!=0: the write SHALL occur and busy SHALL end at 1 (set wins).
REQ-021 pend_set on an already-busy register SHALL leave it busy; this is not an error and no count is kept.
REQ-022 busy[0] SHALL always be 0.
REQ-023 stall = OR over N in {1,2} of (rsN!=0 and busy[rsN] and not fwdN); fwdN = BYPASS and wb_en and wb_rd=rsN.
REQ-024 stall SHALL be combinational from the current busy, rs1/rs2 and writeback inputs, with zero-cycle latency.
REQ-025 A write to a non-busy register SHALL be accepted normally and leave its busy bit at 0.

Reset
REQ-026 At a rising edge with rst=1, all registers SHALL become 0 and busy SHALL become 0; wb_en and pend_set are ignored on that edge.
REQ-027 During and immediately after reset, rs1_data=rs2_data=0 for every index, except through forwarding (REQ-016), and stall=0.
REQ-028 rst asserted while registers are pending SHALL clear all pending state; a later writeback to such a register SHALL be a normal write.

Verification
REQ-029 Reset, then write x5=0xDEADBEEF; next cycle rs1=5 -> rs1_data=0xDEADBEEF; rs2=0 -> 0.
REQ-030 Write x0=0x1234 with wb_en=1 -> rs1=0 reads 0, and busy[0] stays 0.
REQ-031 BYPASS=1: x7=0x11, same cycle wb_en=1, wb_rd=7, wb_data=0x22, rs2=7 -> rs2_data=0x22 combinationally, stall=0. Repeat with BYPASS=0 -> rs2_data=0x11, then 0x22 next cycle.
REQ-032 pend_set, pend_rd=9; next cycle rs1=9 -> stall=1, busy=0x200. wb_en, wb_rd=9, wb_data=0x55 -> stall=0 that cycle (BYPASS=1), rs1_data=0x55; busy=0 next cycle.
REQ-033 Same edge: pend_set, pend_rd=3, and wb_en, wb_rd=3, data 0xA -> reg x3=0xA and busy[3]=1 afterward.
REQ-034 Set busy bits 4 and 6, write x4=0xF, then assert rst for one cycle -> busy=0, all reads 0, stall=0; a subsequent write to x6 succeeds.
